// File: rtl/tile_renderer.sv
// Per-tile draw sequencer: clears one board cell to its background colour, then runs
// the shared number drawer over it and forwards the drawer's pixel stream to the VGA adapter.
module tile_renderer #(
  parameter int unsigned TILE_PITCH   = 30,
  parameter int unsigned GRID_X0      = 20,
  parameter int unsigned GRID_Y0      = 0,
  parameter int unsigned DIGIT_CYCLES = 131,
  parameter logic [2:0]  BG_COLOUR    = 3'b111,
  parameter logic [2:0]  FG_COLOUR    = 3'b000,
  parameter logic [2:0]  BLANK_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] tile_pos,
  input  logic [3:0] tile_value,
  output logic       busy,
  output logic       done,
  output logic [7:0] num_x_base,
  output logic [6:0] num_y_base,
  output logic [3:0] num_sel,
  output logic       num_en,
  output logic       num_rstn,
  input  logic [7:0] num_x,
  input  logic [6:0] num_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int unsigned PixW = $clog2(TILE_PITCH);
  localparam int unsigned CntW = $clog2(DIGIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StClear, StDigits, StDone} state_e;

  state_e            state_q;
  logic [PixW-1:0]   cx_q, cy_q;
  logic [CntW-1:0]   dcnt_q;
  logic [7:0]        base_x_q, base_x_d;
  logic [6:0]        base_y_q, base_y_d;
  logic [3:0]        value_q;

  always_comb begin
    base_x_d = 8'(GRID_X0 + {30'd0, tile_pos[1:0]} * TILE_PITCH);
    base_y_d = 7'(GRID_Y0 + {30'd0, tile_pos[3:2]} * TILE_PITCH);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cx_q     <= '0;
      cy_q     <= '0;
      dcnt_q   <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      value_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            value_q  <= tile_value;
            cx_q     <= '0;
            cy_q     <= '0;
            dcnt_q   <= '0;
            state_q  <= StClear;
          end
        end
        StClear: begin
          if (cx_q == PixW'(TILE_PITCH - 1)) begin
            cx_q <= '0;
            if (cy_q == PixW'(TILE_PITCH - 1)) begin
              cy_q    <= '0;
              state_q <= (value_q != 4'd0) ? StDigits : StDone;
            end else begin
              cy_q <= cy_q + 1'b1;
            end
          end else begin
            cx_q <= cx_q + 1'b1;
          end
        end
        StDigits: begin
          if (dcnt_q == CntW'(DIGIT_CYCLES - 1)) begin
            dcnt_q  <= '0;
            state_q <= StDone;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign num_x_base = base_x_q;
  assign num_y_base = base_y_q;
  assign num_sel    = value_q;

  // Drawer is held in reset outside DIGITS so each pass starts at its counter 0.
  always_comb begin
    num_en     = 1'b0;
    num_rstn   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state_q)
      StClear: begin
        vga_x      = base_x_q + 8'(cx_q);
        vga_y      = base_y_q + 7'(cy_q);
        vga_colour = (value_q == 4'd0) ? BLANK_COLOUR : BG_COLOUR;
        vga_plot   = 1'b1;
      end
      StDigits: begin
        num_en     = 1'b1;
        num_rstn   = 1'b1;
        vga_x      = num_x;
        vga_y      = num_y;
        vga_colour = FG_COLOUR;
        vga_plot   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed self-checking bench for tile_renderer with a simple counting number-drawer model.
module tb_tile_renderer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b1;
  logic [3:0] tile_pos = 4'd0;
  logic [3:0] tile_value = 4'd0;
  logic       busy, done, num_en, num_rstn, vga_plot;
  logic [7:0] num_x_base, num_x, vga_x;
  logic [6:0] num_y_base, num_y, vga_y;
  logic [3:0] num_sel;
  logic [2:0] vga_colour;

  tile_renderer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .tile_pos   (tile_pos),
    .tile_value (tile_value),
    .busy       (busy),
    .done       (done),
    .num_x_base (num_x_base),
    .num_y_base (num_y_base),
    .num_sel    (num_sel),
    .num_en     (num_en),
    .num_rstn   (num_rstn),
    .num_x      (num_x),
    .num_y      (num_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  // Drawer model: counter walks a 10-wide raster offset from the supplied base.
  logic [7:0] dcnt;
  always @(posedge clk) begin
    if (!num_rstn) dcnt <= 8'd0;
    else if (num_en) dcnt <= dcnt + 8'd1;
  end
  assign num_x = num_x_base + (dcnt % 8'd10);
  assign num_y = num_y_base + 7'(dcnt / 8'd10);

  int n_asserts = 0;
  int n_fail = 0;

  int done_cyc, plots, fg_plots, fg_bad, oob, clear_bad, busy_bad, rise_cyc, en_cycles;
  logic [7:0] first_x, last_x, rise_bx, rise_vx;
  logic [6:0] first_y, last_y, rise_by, rise_vy;
  logic [2:0] first_col;
  logic [3:0] rise_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one tile and monitors it until done (or a cycle budget expires).
  task automatic draw(input logic [3:0] pos, input logic [3:0] val, input int pa, input int pb);
    int bx, by, ex, ey;
    logic [2:0] ecol;
    bx = 20 + 30 * int'(pos[1:0]);
    by = 30 * int'(pos[3:2]);
    ecol = (val == 4'd0) ? 3'b000 : 3'b111;
    done_cyc = -1; plots = 0; fg_plots = 0; fg_bad = 0; oob = 0;
    clear_bad = 0; busy_bad = 0; rise_cyc = -1; en_cycles = 0;
    tile_pos = pos; tile_value = val; start = 1'b1;
    step();
    start = 1'b0; tile_pos = ~pos; tile_value = ~val;
    for (int c = 1; c <= 1100; c++) begin
      if (busy !== 1'b1) busy_bad++;
      if (vga_plot === 1'b1) begin
        plots++;
        if (vga_x >= 8'd160 || vga_y >= 7'd120) oob++;
      end
      if (num_en === 1'b1) en_cycles++;
      if (c <= 900) begin
        ex = bx + (c - 1) % 30;
        ey = by + (c - 1) / 30;
        if (vga_plot !== 1'b1 || int'(vga_x) != ex || int'(vga_y) != ey || vga_colour !== ecol
            || num_rstn !== 1'b0)
          clear_bad++;
        if (c == 1) begin first_x = vga_x; first_y = vga_y; first_col = vga_colour; end
        if (c == 900) begin last_x = vga_x; last_y = vga_y; end
      end
      if (num_rstn === 1'b1) begin
        fg_plots++;
        if (rise_cyc < 0) begin
          rise_cyc = c; rise_bx = num_x_base; rise_by = num_y_base; rise_sel = num_sel;
          rise_vx = vga_x; rise_vy = vga_y;
        end
        if (vga_x !== num_x || vga_y !== num_y || vga_colour !== 3'b000 || vga_plot !== 1'b1)
          fg_bad++;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (c == pa || c == pb) start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    // Reset held with start asserted
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_plot", 32'(vga_plot), 32'd0);
      chk("rst_num_rstn", 32'(num_rstn), 32'd0);
    end
    chk("rst_num_sel", 32'(num_sel), 32'd0);
    chk("rst_vga_x", 32'(vga_x), 32'd0);
    resetn = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Tile 0 with value 5
    draw(4'd0, 4'd5, -1, -1);
    chk("t5_first_x", 32'(first_x), 32'd20);
    chk("t5_first_y", 32'(first_y), 32'd0);
    chk("t5_first_col", 32'(first_col), 32'd7);
    chk("t5_last_x", 32'(last_x), 32'd49);
    chk("t5_last_y", 32'(last_y), 32'd29);
    chk("t5_clear_bad", 32'(clear_bad), 32'd0);
    chk("t5_rise_cyc", 32'(rise_cyc), 32'd901);
    chk("t5_rise_bx", 32'(rise_bx), 32'd20);
    chk("t5_rise_by", 32'(rise_by), 32'd0);
    chk("t5_rise_sel", 32'(rise_sel), 32'd5);
    chk("t5_fg_plots", 32'(fg_plots), 32'd131);
    chk("t5_fg_bad", 32'(fg_bad), 32'd0);
    chk("t5_done_cyc", 32'(done_cyc), 32'd1032);
    chk("t5_busy_bad", 32'(busy_bad), 32'd0);
    step();
    chk("t5_after_busy", 32'(busy), 32'd0);
    chk("t5_after_done", 32'(done), 32'd0);

    // Blank tile 15
    draw(4'd15, 4'd0, -1, -1);
    chk("blank_first_x", 32'(first_x), 32'd110);
    chk("blank_first_y", 32'(first_y), 32'd90);
    chk("blank_first_col", 32'(first_col), 32'd0);
    chk("blank_last_x", 32'(last_x), 32'd139);
    chk("blank_last_y", 32'(last_y), 32'd119);
    chk("blank_clear_bad", 32'(clear_bad), 32'd0);
    chk("blank_en_cycles", 32'(en_cycles), 32'd0);
    chk("blank_done_cyc", 32'(done_cyc), 32'd901);
    step();

    // Start pulses during a draw are ignored; start in done cycle is ignored too
    draw(4'd0, 4'd9, 100, 500);
    chk("ign_done_cyc", 32'(done_cyc), 32'd1032);
    chk("ign_plots", 32'(plots), 32'd1031);
    start = 1'b1;
    step();
    chk("ign_done_start", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    chk("accept_1033", 32'(busy), 32'd1);

    // Reset in the middle of DIGITS (relative cycle 950)
    for (int i = 1; i < 950; i++) step();
    chk("mid_digits_en", 32'(num_en), 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_plot", 32'(vga_plot), 32'd0);
    chk("abort_num_rstn", 32'(num_rstn), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end

    draw(4'd6, 4'd13, -1, -1);
    chk("t13_rise_bx", 32'(rise_bx), 32'd80);
    chk("t13_rise_by", 32'(rise_by), 32'd30);
    chk("t13_drawer_x0", 32'(rise_vx), 32'd80);
    chk("t13_drawer_y0", 32'(rise_vy), 32'd30);
    chk("t13_rise_sel", 32'(rise_sel), 32'd13);
    chk("t13_done_cyc", 32'(done_cyc), 32'd1032);
    step();

    // Sweep all positions, value = position
    for (int p = 0; p < 16; p++) begin
      draw(4'(p), 4'(p), -1, -1);
      chk("sweep_plots", 32'(plots), (p == 0) ? 32'd900 : 32'd1031);
      chk("sweep_oob", 32'(oob), 32'd0);
      chk("sweep_clear_bad", 32'(clear_bad), 32'd0);
      chk("sweep_fg_bad", 32'(fg_bad), 32'd0);
      chk("sweep_done_cyc", 32'(done_cyc), (p == 0) ? 32'd901 : 32'd1032);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
# tile_renderer

Per-tile draw sequencer for the sliding-puzzle display. On a start request it clears one 30x30 tile cell of the 4x4 board to background colour, then runs the shared number drawer for that tile's value, passing the drawer's pixel stream to the VGA adapter. It sits between the board-update logic (upstream) and the number drawers plus VGA adapter (downstream). It supplies the drawer's base coordinates, enable and reset, and consumes the drawer's absolute x/y.

## Interface
Parameters:
- TILE_PITCH, 30: tile edge length and spacing in pixels.
- GRID_X0, 20: screen x of the board's top-left pixel.
- GRID_Y0, 0: screen y of the board's top-left pixel.
- DIGIT_CYCLES, 131: cycles per number-drawer pass, covering drawer counter values 0..130.
- BG_COLOUR, 3'b111: tile background colour.
- FG_COLOUR, 3'b000: digit stroke colour.
- BLANK_COLOUR, 3'b000: fill colour for the empty tile (value 0).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  draw request; sampled only in IDLE.
- tile_pos  in  4  board cell; col = [1:0], row = [3:2].
- tile_value  in  4  number on the tile; 0 = blank.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when the tile is finished.
- num_x_base  out  8  drawer xIn, equal to the tile base x.
- num_y_base  out  7  drawer yIn, equal to the tile base y.
- num_sel  out  4  latched tile_value; selects which drawer instance is muxed onto num_x/num_y.
- num_en  out  1  drawer enable.
- num_rstn  out  1  drawer reset (active-low).
- num_x  in  8  drawer xOut.
- num_y  in  7  drawer yOut.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe.

## Operation
- States: IDLE, CLEAR, DIGITS, DONE.
- **IDLE**
  - When start=1, latch tile_pos and tile_value, and go to CLEAR.
  - Base coordinates: base_x = GRID_X0 + col·TILE_PITCH; base_y = GRID_Y0 + row·TILE_PITCH.
  - Compute base in 8 bits (x) and 7 bits (y). No overflow occurs with the default parameters; tile 15 gives base (110, 90).
- **CLEAR**
  - Raster counters cx, cy run 0..TILE_PITCH-1, with cx as the inner loop.
  - Outputs: vga_x = base_x + cx, vga_y = base_y + cy, vga_plot = 1.
  - vga_colour = BG_COLOUR, or BLANK_COLOUR when latched value = 0.
  - After pixel (29,29): go to DIGITS if value ≠ 0, otherwise go to DONE.
- **DIGITS**
  - Drive num_rstn = 1 and num_en = 1.
  - Pass through vga_x = num_x and vga_y = num_y combinationally, with vga_plot = 1 and vga_colour = FG_COLOUR.
  - A cycle counter runs 0..DIGIT_CYCLES-1; the state then goes to DONE.
- **DONE**
  - done = 1 for one cycle, then return to IDLE.
- **Drawer control outside DIGITS**
  - num_rstn = 0 and num_en = 0, so every DIGITS pass starts at drawer counter 0.
  - num_x_base and num_y_base are held at the latched base at all times after acceptance.
- vga_plot = 0 in IDLE and DONE.
- start while busy is ignored; no queueing.
- Inputs tile_pos and tile_value are don't-care after acceptance.

## Timing
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE; all counters go to 0; busy=0, done=0, vga_plot=0, num_en=0, num_rstn=0.
  - vga_x, vga_y, vga_colour, num_x_base, num_y_base and num_sel all go to 0.
- Reset mid-operation aborts the tile immediately; no done is issued.
- With start sampled at edge 0:
  - CLEAR occupies cycles 1..900.
  - DIGITS occupies cycles 901..1031.
  - done is high in cycle 1032.
  - busy is high in cycles 1..1032.
- Blank tile: CLEAR occupies cycles 1..900 and done is high in cycle 901.
- A start asserted in the same cycle done is high is ignored; start is accepted in the following IDLE cycle.
- Throughput: one tile per 1033 cycles (non-blank).

## Test plan
- Reset: hold resetn=0 for 3 cycles with start=1.
  -> busy=0, vga_plot=0, num_rstn=0.
  -> After release with start=0, the block stays idle.
- Tile pos=0, value=5:
  -> First plot at (20,0) in BG_COLOUR; 900th plot at (49,29).
  -> num_rstn rises in cycle 901 with base (20,0) and num_sel=5.
  -> 131 FG plots, each equal to num_x/num_y.
  -> done in cycle 1032.
- Blank tile: pos=15, value=0.
  -> Clear spans (110,90)..(139,119) in BLANK_COLOUR.
  -> num_en never rises; done in cycle 901.
- start pulsed at cycles 100 and 500 during a draw.
  -> Both pulses are ignored; a single done at 1032.
  -> A start at cycle 1033 begins a new tile.
- resetn=0 at cycle 950 (mid-DIGITS).
  -> Next cycle: IDLE, plot=0, num_rstn=0, no done.
  -> A following draw of pos=6, value=13 starts the drawer from counter 0 with base (80,30).
- Sweep all 16 positions.
  -> Per-tile plot count is 1031 (900 for value 0).
  -> No coordinate leaves 160x120.
